eca_job_seq: RTL and testbench
==============================

ECA_JOB_SEQ -- requirements
Module: eca_job_seq

Interface
REQ-001 SHALL have parameter K_MAX, default 8, max data blocks per stripe.
REQ-002 SHALL have parameter M_MAX, default 4, max parity rows per stripe.
REQ-003 SHALL have parameter BM_MEM_ADDR_W, default 8, bitmatrix memory address width.
REQ-004 SHALL have parameter PKT_CNT_W, default 16, packet counter width; derived CW = clog2(max(K_MAX,M_MAX))+1.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports start in 1 (job start pulse); abort in 1 (job abort).
REQ-008 SHALL have ports k_val in CW; m_val in CW; pkt_num in PKT_CNT_W; bm_base_addr in BM_MEM_ADDR_W (job config, sampled at start).
REQ-009 SHALL have ports inbuf_empty in 1; inbuf_rd_rq out 1 (pop one packet).
REQ-010 SHALL have ports bm_rd_rq out 1; bm_rd_addr out BM_MEM_ADDR_W; bm_rd_data_val in 1.
REQ-011 SHALL have ports eng_calc_en out 1; bm_col_val out 1; eng_data_used in 1; outbuf_full in 1.
REQ-012 SHALL have ports busy out 1; done out 1 (pulse); err out 1 (sticky); pkt_cnt out PKT_CNT_W; row_idx out CW.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD_PKT, FETCH, WAIT_COL, CALC, NEXT, DONE; busy=1 in every state except IDLE.
REQ-014 IDLE: start with valid config SHALL latch config, clear pkt_cnt and err, go to LOAD_PKT next cycle.
REQ-015 Invalid config (k_val==0, k_val>K_MAX, m_val==0, m_val>M_MAX, pkt_num==0) at start SHALL set err=1, stay IDLE, latch nothing.
REQ-016 LOAD_PKT: when inbuf_empty==0 and outbuf_full==0, inbuf_rd_rq SHALL be 1 for exactly that cycle, row_idx cleared to 0, go to FETCH; otherwise SHALL wait with inbuf_rd_rq=0.
REQ-017 FETCH: bm_rd_rq SHALL be 1 for one cycle with bm_rd_addr = (bm_base_addr + row_idx) mod 2^BM_MEM_ADDR_W; go to WAIT_COL.
REQ-018 WAIT_COL: on bm_rd_data_val=1, bm_col_val SHALL pulse 1 on the following cycle and FSM enter CALC; no timeout.
REQ-019 CALC: eng_calc_en SHALL equal ~outbuf_full; eng_data_used SHALL be honoured only when eng_calc_en=1.
REQ-020 CALC on honoured eng_data_used: row_idx==m_val-1 -> NEXT; else row_idx+1 -> FETCH.
REQ-021 NEXT (one cycle): pkt_cnt SHALL increment; if new pkt_cnt==pkt_num -> DONE, else -> LOAD_PKT.
REQ-022 DONE (one cycle): done SHALL be 1, then IDLE; pkt_cnt holds final value until next valid start.
REQ-023 start while busy SHALL be ignored (no relatch, no err change).
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE next cycle, suppress done, deassert all strobes, hold pkt_cnt; abort has priority over every other transition; abort in IDLE has no effect.
REQ-025 bm_rd_data_val or eng_data_used outside WAIT_COL / CALC SHALL be ignored.
REQ-026 Config latched at start SHALL be used for whole job; k_val carried for engine/status only, not affecting sequencing.
REQ-027 pkt_cnt SHALL not wrap within a job (pkt_num bounds it).

Reset
REQ-028 rstn=0 SHALL asynchronously force IDLE; busy, done, err, inbuf_rd_rq, bm_rd_rq, bm_col_val, eng_calc_en=0; bm_rd_addr, pkt_cnt, row_idx=0; latched config=0.
REQ-029 Reset mid-job SHALL discard job; after release module SHALL accept new start with no residual state.

Verification
REQ-030 k=4,m=2,pkt_num=3,base=0x10, inbuf never empty, eng_data_used 2 cycles after each eng_calc_en rise -> 3 inbuf_rd_rq, 6 bm reads at 0x10,0x11 repeated, pkt_cnt=3, one done pulse.
REQ-031 base=0xFE,m=4,pkt_num=1 -> bm_rd_addr sequence 0xFE,0xFF,0x00,0x01.
REQ-032 start with m_val=0 then start with m_val=M_MAX+1 -> err=1, busy=0, no rd_rq; subsequent valid start -> err=0, job runs.
REQ-033 outbuf_full=1 during CALC for 5 cycles with eng_data_used asserted -> eng_calc_en=0 for those 5 cycles, row_idx unchanged; full in LOAD_PKT -> no inbuf_rd_rq.
REQ-034 abort during WAIT_COL of packet 2 of 4 -> IDLE next cycle, pkt_cnt=1, no done; late bm_rd_data_val ignored.
REQ-035 rstn pulsed low during CALC -> all outputs 0 immediately; new job after release completes normally.

Source files
------------

// File: rtl/eca_job_seq_if.sv
// Handshake bundle between the job sequencer (master) and the input buffer,
// bitmatrix memory and coding engine (slave).
interface eca_job_seq_if #(
   parameter int unsigned BM_MEM_ADDR_W = 8,
   parameter int unsigned CW            = 4
);
   logic                     inbuf_empty;
   logic                     inbuf_rd_rq;
   logic                     bm_rd_rq;
   logic [BM_MEM_ADDR_W-1:0] bm_rd_addr;
   logic                     bm_rd_data_val;
   logic                     eng_calc_en;
   logic                     bm_col_val;
   logic                     eng_data_used;
   logic                     outbuf_full;
   logic [CW-1:0]            eng_k;

   modport master (
      input  inbuf_empty, bm_rd_data_val, eng_data_used, outbuf_full,
      output inbuf_rd_rq, bm_rd_rq, bm_rd_addr, eng_calc_en, bm_col_val, eng_k
   );

   modport slave (
      output inbuf_empty, bm_rd_data_val, eng_data_used, outbuf_full,
      input  inbuf_rd_rq, bm_rd_rq, bm_rd_addr, eng_calc_en, bm_col_val, eng_k
   );
endinterface

// File: rtl/eca_job_seq.sv
// Erasure-coding job sequencer: per packet pops the input buffer, then walks m parity rows,
// fetching one bitmatrix column per row and handing it to the engine.
module eca_job_seq #(
   parameter int unsigned K_MAX         = 8,
   parameter int unsigned M_MAX         = 4,
   parameter int unsigned BM_MEM_ADDR_W = 8,
   parameter int unsigned PKT_CNT_W     = 16,
   localparam int unsigned CW = $clog2((K_MAX > M_MAX) ? K_MAX : M_MAX) + 1
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     start_i,
   input  logic                     abort_i,
   input  logic [CW-1:0]            k_val_i,
   input  logic [CW-1:0]            m_val_i,
   input  logic [PKT_CNT_W-1:0]     pkt_num_i,
   input  logic [BM_MEM_ADDR_W-1:0] bm_base_addr_i,
   eca_job_seq_if.master            job_bus,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic [PKT_CNT_W-1:0]     pkt_cnt_o,
   output logic [CW-1:0]            row_idx_o
);

   localparam logic [CW-1:0] KMaxW = CW'(K_MAX);
   localparam logic [CW-1:0] MMaxW = CW'(M_MAX);

   typedef enum logic [2:0] {
      StIdle, StLoadPkt, StFetch, StWaitCol, StCalc, StNext, StDone
   } state_e;

   state_e                   state_q, state_d;
   logic [CW-1:0]            k_q, k_d;
   logic [CW-1:0]            m_q, m_d;
   logic [PKT_CNT_W-1:0]     num_q, num_d;
   logic [BM_MEM_ADDR_W-1:0] base_q, base_d;
   logic [PKT_CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;
   logic [CW-1:0]            row_q, row_d;
   logic                     err_q, err_d;
   logic                     col_q, col_d;

   logic                     cfg_bad;
   logic [PKT_CNT_W-1:0]     pkt_inc;
   logic                     inbuf_rd_rq;
   logic                     bm_rd_rq;
   logic                     eng_calc_en;
   logic                     done;

   assign cfg_bad = (k_val_i == '0) || (k_val_i > KMaxW) ||
                    (m_val_i == '0) || (m_val_i > MMaxW) ||
                    (pkt_num_i == '0);
   assign pkt_inc = pkt_cnt_q + PKT_CNT_W'(1);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= StIdle;
         k_q       <= '0;
         m_q       <= '0;
         num_q     <= '0;
         base_q    <= '0;
         pkt_cnt_q <= '0;
         row_q     <= '0;
         err_q     <= 1'b0;
         col_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         m_q       <= m_d;
         num_q     <= num_d;
         base_q    <= base_d;
         pkt_cnt_q <= pkt_cnt_d;
         row_q     <= row_d;
         err_q     <= err_d;
         col_q     <= col_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      m_d         = m_q;
      num_d       = num_q;
      base_d      = base_q;
      pkt_cnt_d   = pkt_cnt_q;
      row_d       = row_q;
      err_d       = err_q;
      col_d       = 1'b0;
      inbuf_rd_rq = 1'b0;
      bm_rd_rq    = 1'b0;
      eng_calc_en = 1'b0;
      done        = 1'b0;

      // Abort outranks every transition and silences all strobes in its cycle.
      if (abort_i && (state_q != StIdle)) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  if (cfg_bad) begin
                     err_d = 1'b1;
                  end else begin
                     k_d       = k_val_i;
                     m_d       = m_val_i;
                     num_d     = pkt_num_i;
                     base_d    = bm_base_addr_i;
                     pkt_cnt_d = '0;
                     row_d     = '0;
                     err_d     = 1'b0;
                     state_d   = StLoadPkt;
                  end
               end
            end
            StLoadPkt: begin
               if (!job_bus.inbuf_empty && !job_bus.outbuf_full) begin
                  inbuf_rd_rq = 1'b1;
                  row_d       = '0;
                  state_d     = StFetch;
               end
            end
            StFetch: begin
               bm_rd_rq = 1'b1;
               state_d  = StWaitCol;
            end
            StWaitCol: begin
               if (job_bus.bm_rd_data_val) begin
                  col_d   = 1'b1;
                  state_d = StCalc;
               end
            end
            StCalc: begin
               eng_calc_en = ~job_bus.outbuf_full;
               if (eng_calc_en && job_bus.eng_data_used) begin
                  if (row_q == m_q - CW'(1)) begin
                     state_d = StNext;
                  end else begin
                     row_d   = row_q + CW'(1);
                     state_d = StFetch;
                  end
               end
            end
            StNext: begin
               pkt_cnt_d = pkt_inc;
               state_d   = (pkt_inc == num_q) ? StDone : StLoadPkt;
            end
            StDone: begin
               done    = 1'b1;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign job_bus.inbuf_rd_rq = inbuf_rd_rq;
   assign job_bus.bm_rd_rq    = bm_rd_rq;
   assign job_bus.bm_rd_addr  = bm_rd_rq ? (base_q + BM_MEM_ADDR_W'(row_q)) : '0;
   assign job_bus.eng_calc_en = eng_calc_en;
   assign job_bus.bm_col_val  = col_q & ~abort_i;
   assign job_bus.eng_k       = k_q;

   assign busy_o    = (state_q != StIdle);
   assign done_o    = done;
   assign err_o     = err_q;
   assign pkt_cnt_o = pkt_cnt_q;
   assign row_idx_o = row_q;

`ifndef SYNTHESIS
   a_strobe_excl: assert property (@(posedge clk_i) disable iff (!rstn_i)
      $onehot0({inbuf_rd_rq, bm_rd_rq, eng_calc_en, done}));
   a_no_calc_when_full: assert property (@(posedge clk_i) disable iff (!rstn_i)
      eng_calc_en |-> !job_bus.outbuf_full);
   a_row_in_range: assert property (@(posedge clk_i) disable iff (!rstn_i)
      busy_o |-> (row_q < m_q));
   a_done_then_idle: assert property (@(posedge clk_i) disable iff (!rstn_i)
      done |=> !busy_o);
`endif

endmodule

// File: tb/tb_eca_job_seq.sv
// Scoreboard bench for eca_job_seq: a job-level model queues the expected pop/read/done
// events; a monitor pops and compares them whenever the DUT strobes.
module tb_eca_job_seq;
   localparam int unsigned K_MAX = 8;
   localparam int unsigned M_MAX = 4;
   localparam int unsigned AW    = 8;
   localparam int unsigned PW    = 16;
   localparam int unsigned CW    = $clog2((K_MAX > M_MAX) ? K_MAX : M_MAX) + 1;
   localparam int          LIMIT = 5000;

   typedef struct packed {
      logic [1:0]  kind;  // 0 pop, 1 bitmatrix read, 2 done
      logic [15:0] val;
   } ev_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0, abort = 1'b0;
   logic [CW-1:0] k_val = '0, m_val = '0;
   logic [PW-1:0] pkt_num = '0;
   logic [AW-1:0] base = '0;
   logic          busy, done, err;
   logic [PW-1:0] pkt_cnt;
   logic [CW-1:0] row_idx;

   int  n_vec = 0, n_err = 0, done_seen = 0;
   ev_t exp_q[$];

   // environment knobs
   logic rand_io = 1'b0, man_empty = 1'b1, man_full = 1'b0, man_used = 1'b0, bm_auto = 1'b1;
   int   eng_mode = 2;
   int   poke_req = 0;

   eca_job_seq_if #(.BM_MEM_ADDR_W(AW), .CW(CW)) bus ();

   eca_job_seq #(.K_MAX(K_MAX), .M_MAX(M_MAX), .BM_MEM_ADDR_W(AW), .PKT_CNT_W(PW)) dut (
      .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
      .k_val_i(k_val), .m_val_i(m_val), .pkt_num_i(pkt_num), .bm_base_addr_i(base),
      .job_bus(bus), .busy_o(busy), .done_o(done), .err_o(err),
      .pkt_cnt_o(pkt_cnt), .row_idx_o(row_idx)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_ev(input logic [1:0] kind, input logic [15:0] val);
      ev_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got kind %0d val 0x%0h, want none", kind, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== kind || e.val !== val) begin
            n_err++;
            $display("FAIL event_seq: got kind %0d val 0x%0h, want kind %0d val 0x%0h",
                     kind, val, e.kind, e.val);
         end
      end
   endtask

   // Reference model: every packet is one pop then m column reads at base, base+1, ...
   task automatic model_job(input int m, input int num, input int b);
      for (int p = 0; p < num; p++) begin
         exp_q.push_back('{kind: 2'd0, val: 16'(p)});
         for (int r = 0; r < m; r++) exp_q.push_back('{kind: 2'd1, val: 16'((b + r) % 256)});
      end
      exp_q.push_back('{kind: 2'd2, val: 16'(num)});
   endtask

   // monitor
   initial forever begin
      @(negedge clk);
      if (rstn) begin
         if (bus.inbuf_rd_rq) check_ev(2'd0, pkt_cnt);
         if (bus.bm_rd_rq) check_ev(2'd1, {8'h00, bus.bm_rd_addr});
         if (done) begin
            done_seen++;
            check_ev(2'd2, pkt_cnt);
         end
         if (bus.outbuf_full) chk("calc_en_while_full", {31'd0, bus.eng_calc_en}, 32'd0);
      end
   end

   // buffer / memory / engine responder
   initial begin : env
      int cnt, seen, run;
      cnt = 0; seen = 0; run = 0;
      bus.inbuf_empty = 1'b1; bus.outbuf_full = 1'b0;
      bus.eng_data_used = 1'b0; bus.bm_rd_data_val = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (rand_io) begin
            bus.inbuf_empty = ($urandom_range(0, 3) == 0);
            bus.outbuf_full = ($urandom_range(0, 4) == 0);
         end else begin
            bus.inbuf_empty = man_empty;
            bus.outbuf_full = man_full;
         end
         run = bus.eng_calc_en ? run + 1 : 0;
         case (eng_mode)
            0:       bus.eng_data_used = ($urandom_range(0, 2) == 0);
            1:       bus.eng_data_used = (run == 2);
            default: bus.eng_data_used = man_used;
         endcase
         bus.bm_rd_data_val = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) bus.bm_rd_data_val = 1'b1;
         end else if (bm_auto && bus.bm_rd_rq) begin
            cnt = $urandom_range(1, 3);
         end
         if (rand_io && $urandom_range(0, 7) == 0) bus.bm_rd_data_val = 1'b1;
         if (poke_req != seen) begin
            seen = poke_req;
            bus.bm_rd_data_val = 1'b1;
         end
      end
   end

   task automatic start_job(input int k, input int m, input int num, input int b);
      @(posedge clk); #1;
      k_val = CW'(k); m_val = CW'(m); pkt_num = PW'(num); base = AW'(b); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_to_end(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || exp_q.size() != 0) && n < LIMIT);
      if (n >= LIMIT) begin
         n_vec++; n_err++;
         $display("FAIL %s_timeout: got %0d pending events, want 0", name, exp_q.size());
         exp_q.delete();
         @(posedge clk); #1 abort = 1'b1;
         @(posedge clk); #1 abort = 1'b0;
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_strobes"}, {25'd0, busy, done, err, bus.inbuf_rd_rq, bus.bm_rd_rq,
          bus.bm_col_val, bus.eng_calc_en}, 32'd0);
      chk({name, "_addr_row"}, {20'd0, bus.bm_rd_addr, row_idx}, 32'd0);
      chk({name, "_pkt_cnt"}, {16'd0, pkt_cnt}, 32'd0);
   endtask

   initial begin
      int n, d0;
      // reset state
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1 rstn = 1'b1;

      // basic job, deterministic engine
      man_empty = 1'b0; man_full = 1'b0; eng_mode = 1;
      d0 = done_seen;
      model_job(2, 3, 'h10);
      start_job(4, 2, 3, 'h10);
      @(negedge clk);
      chk("eng_k_latched", {28'd0, bus.eng_k}, 32'd4);
      run_to_end("basic");
      chk("basic_pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
      chk("basic_done_pulses", done_seen - d0, 32'd1);

      // address wrap
      model_job(4, 1, 'hFE);
      start_job(2, 4, 1, 'hFE);
      run_to_end("wrap");
      chk("wrap_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);

      // invalid configurations
      begin
         int bad[5][3] = '{'{4, 0, 1}, '{4, M_MAX + 1, 1}, '{0, 2, 1}, '{K_MAX + 1, 2, 1},
                           '{4, 2, 0}};
         for (int i = 0; i < 5; i++) begin
            start_job(bad[i][0], bad[i][1], bad[i][2], 'h55);
            repeat (2) @(negedge clk);
            chk($sformatf("bad%0d_err", i), {31'd0, err}, 32'd1);
            chk($sformatf("bad%0d_busy", i), {31'd0, busy}, 32'd0);
            chk($sformatf("bad%0d_pkt_cnt", i), {16'd0, pkt_cnt}, 32'd1);
         end
      end
      model_job(1, 2, 'h40);
      start_job(2, 1, 2, 'h40);
      @(negedge clk);
      chk("recover_err", {31'd0, err}, 32'd0);
      chk("recover_busy", {31'd0, busy}, 32'd1);
      run_to_end("recover");

      // output buffer back-pressure
      man_full = 1'b1; man_used = 1'b0; eng_mode = 2;
      model_job(2, 1, 'h20);
      start_job(3, 2, 1, 'h20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("full_load_no_pop", {31'd0, bus.inbuf_rd_rq}, 32'd0);
      end
      @(posedge clk); #1 man_full = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.bm_col_val && n < LIMIT);
      chk("full_reach_calc", {31'd0, n < LIMIT}, 32'd1);
      @(posedge clk); #1 man_full = 1'b1; man_used = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("full_calc_en", {31'd0, bus.eng_calc_en}, 32'd0);
         chk("full_row_hold", {28'd0, row_idx}, 32'd0);
      end
      @(posedge clk); #1 man_full = 1'b0;
      @(negedge clk);
      chk("unfull_calc_en", {31'd0, bus.eng_calc_en}, 32'd1);
      @(posedge clk); #1 eng_mode = 1; man_used = 1'b0;
      @(negedge clk);
      chk("unfull_row_adv", {28'd0, row_idx}, 32'd1);
      run_to_end("full");

      // abort while waiting for the first column of packet 2
      rand_io = 1'b1; eng_mode = 0;
      d0 = done_seen;
      model_job(2, 4, 'h30);
      start_job(5, 2, 4, 'h30);
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!(bus.bm_rd_rq && pkt_cnt == 1 && row_idx == 0) && n < LIMIT);
      chk("abort_reach", {31'd0, n < LIMIT}, 32'd1);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0; poke_req++;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
      chk("abort_remaining", exp_q.size(), 32'd8);
      exp_q.delete();
      repeat (4) @(negedge clk);
      chk("abort_stays_idle", {31'd0, busy}, 32'd0);
      chk("abort_no_done", done_seen - d0, 32'd0);

      // reset in the middle of CALC
      model_job(3, 2, 'h50);
      start_job(6, 3, 2, 'h50);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.bm_col_val && n < LIMIT);
      chk("rst_reach_calc", {31'd0, n < LIMIT}, 32'd1);
      #2 rstn = 1'b0;
      #1 chk_all_zero("midjob_reset");
      exp_q.delete();
      @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
      model_job(1, 3, 'h00);
      start_job(8, 1, 3, 'h00);
      run_to_end("post_reset");
      chk("post_reset_pkt_cnt", {16'd0, pkt_cnt}, 32'd3);

      // random jobs; the first also sees a start while busy with a bad config
      for (int j = 0; j < 8; j++) begin
         int k, m, num, b;
         k = $urandom_range(1, K_MAX); m = $urandom_range(1, M_MAX);
         num = $urandom_range(1, 5); b = $urandom_range(0, 255);
         model_job(m, num, b);
         start_job(k, m, num, b);
         if (j == 0) begin
            k_val = '0; m_val = '0; pkt_num = '0; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            chk("busy_start_err", {31'd0, err}, 32'd0);
         end
         run_to_end($sformatf("rand%0d", j));
         chk($sformatf("rand%0d_pkt_cnt", j), {16'd0, pkt_cnt}, 32'(num));
         chk($sformatf("rand%0d_err", j), {31'd0, err}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
